// File: rtl/chess_board_state_pkg.sv
// chess_board_state_pkg: piece, colour and status codes, FSM states and the start-position table.
package chess_board_state_pkg;
  localparam logic [2:0] P_EMPTY  = 3'd0;
  localparam logic [2:0] P_PAWN   = 3'd1;
  localparam logic [2:0] P_BISHOP = 3'd2;
  localparam logic [2:0] P_KNIGHT = 3'd3;
  localparam logic [2:0] P_ROOK   = 3'd4;
  localparam logic [2:0] P_QUEEN  = 3'd5;
  localparam logic [2:0] P_KING   = 3'd6;
  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_ERR_TURN = 2'd1;
  localparam logic [1:0] ST_ERR_SRC  = 2'd2;
  localparam logic [1:0] ST_ERR_DST  = 2'd3;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CHK, S_WR_DST, S_WR_SRC, S_RESP} state_e;
  function automatic logic [3:0] start_piece(input logic [5:0] idx);
    logic [2:0] x;
    logic [2:0] back;
    x = idx[2:0];
    back = (x == 3'd0 || x == 3'd7) ? P_ROOK :
           (x == 3'd1 || x == 3'd6) ? P_KNIGHT :
           (x == 3'd2 || x == 3'd5) ? P_BISHOP :
           (x == 3'd3) ? P_KING : P_QUEEN;
    return idx[5:3] == 3'd0 ? {BLACK, back} :
           idx[5:3] == 3'd1 ? {BLACK, P_PAWN} :
           idx[5:3] == 3'd6 ? {WHITE, P_PAWN} :
           idx[5:3] == 3'd7 ? {WHITE, back} : 4'h0;
  endfunction
endpackage

// File: rtl/chess_board_state_if.sv
// chess_board_state_if: move request/response channel between move generator and board store.
interface chess_board_state_if;
  logic       valid;
  logic       ready;
  logic [2:0] src_x;
  logic [2:0] src_y;
  logic [2:0] dst_x;
  logic [2:0] dst_y;
  logic       colour;
  logic       done;
  logic [1:0] status;
  logic [3:0] captured;
  modport master (output valid, src_x, src_y, dst_x, dst_y, colour, input ready, done, status, captured);
  modport slave  (input valid, src_x, src_y, dst_x, dst_y, colour, output ready, done, status, captured);
endinterface

// File: rtl/chess_board_state_ram.sv
// chess_board_state_ram: 64x4 board store, one sync write, one async FSM read, one registered renderer read.
module chess_board_state_ram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [3:0] i_wdata,
  input  logic [5:0] i_raddr,
  output logic [3:0] o_rdata,
  input  logic [5:0] i_rd_sq,
  output logic [3:0] o_rd_piece
);
  logic [3:0] r_mem [64];
  logic [3:0] r_rd;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd <= '0;
    else        r_rd <= r_mem[i_rd_sq];
  end
  assign o_rdata    = r_mem[i_raddr];
  assign o_rd_piece = r_rd;
endmodule

// File: rtl/chess_board_state.sv
// chess_board_state: board store with start-position init and a turn/occupancy-checked move FSM.
module chess_board_state
  import chess_board_state_pkg::*;
#(
  parameter logic FIRST_TURN = 1'b0,
  parameter bit   PROMOTE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_new_game,
  input  logic [5:0]           i_rd_sq,
  output logic [3:0]           o_rd_piece,
  output logic                 o_turn,
  output logic                 o_init_busy,
  chess_board_state_if.slave   mv
);
  state_e     r_state, w_next;
  logic [5:0] r_idx, r_src, r_dst;
  logic       r_col, r_turn, r_done;
  logic [3:0] r_src_pc, r_dst_pc, r_cap_out;
  logic [1:0] r_status, r_st_out;
  logic       w_accept, w_resp, w_promote, w_we;
  logic [5:0] w_raddr, w_waddr;
  logic [3:0] w_rdata, w_wdata, w_rd;
  logic [1:0] w_status;
  assign w_accept  = mv.valid && mv.ready && !i_new_game;
  assign w_resp    = r_state == S_RESP && !i_new_game;
  assign w_raddr   = r_state == S_RD ? r_src : r_dst;
  // src entry was captured in RD; dst is read live during CHK
  assign w_status  = r_col != r_turn ? ST_ERR_TURN :
                     (r_src_pc[2:0] == P_EMPTY || r_src_pc[3] != r_col) ? ST_ERR_SRC :
                     (r_src == r_dst || (w_rdata[2:0] != P_EMPTY && w_rdata[3] == r_col)) ? ST_ERR_DST : ST_OK;
  assign w_promote = PROMOTE_EN && r_src_pc[2:0] == P_PAWN && r_dst[5:3] == (r_col ? 3'd7 : 3'd0);
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = start_piece(r_idx);
    case (r_state)
      S_INIT:   begin w_we = 1'b1; w_next = r_idx == 6'd63 ? S_IDLE : S_INIT; end
      S_IDLE:   w_next = w_accept ? S_RD : S_IDLE;
      S_RD:     w_next = S_CHK;
      S_CHK:    w_next = w_status == ST_OK ? S_WR_DST : S_RESP;
      S_WR_DST: begin w_we = 1'b1; w_waddr = r_dst; w_wdata = w_promote ? {r_col, P_QUEEN} : r_src_pc; w_next = S_WR_SRC; end
      S_WR_SRC: begin w_we = 1'b1; w_waddr = r_src; w_wdata = 4'h0; w_next = S_RESP; end
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_INIT;
    endcase
    if (i_new_game) begin
      w_next = S_INIT;
      w_we   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0; r_src <= '0; r_dst <= '0; r_col <= 1'b0;
      r_src_pc <= '0; r_dst_pc <= '0; r_status <= '0;
      r_turn <= FIRST_TURN; r_done <= 1'b0; r_st_out <= '0; r_cap_out <= '0;
    end else begin
      r_idx     <= (i_new_game || r_state != S_INIT) ? 6'd0 : r_idx + 6'd1;
      r_done    <= w_resp;
      r_st_out  <= w_resp ? r_status : 2'd0;
      r_cap_out <= (w_resp && r_status == ST_OK) ? r_dst_pc : 4'h0;
      r_turn    <= i_new_game ? FIRST_TURN : (w_resp && r_status == ST_OK) ? ~r_turn : r_turn;
      if (w_accept) begin
        r_src <= {mv.src_y, mv.src_x};
        r_dst <= {mv.dst_y, mv.dst_x};
        r_col <= mv.colour;
      end
      if (r_state == S_RD) r_src_pc <= w_rdata;
      if (r_state == S_CHK) begin
        r_dst_pc <= w_rdata;
        r_status <= w_status;
      end
    end
  end
  chess_board_state_ram u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_raddr    (w_raddr),
    .o_rdata    (w_rdata),
    .i_rd_sq    (i_rd_sq),
    .o_rd_piece (w_rd)
  );
  assign o_init_busy  = r_state == S_INIT;
  assign o_rd_piece   = o_init_busy ? 4'h0 : w_rd;
  assign o_turn       = r_turn;
  assign mv.ready     = r_state == S_IDLE;
  assign mv.done      = r_done;
  assign mv.status    = r_st_out;
  assign mv.captured  = r_cap_out;
endmodule

// File: tb/tb_chess_board_state.sv
// tb_chess_board_state: directed table, corner sequences and random moves against a board-array model.
module tb_chess_board_state;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic [5:0] rd_sq = '0;
  logic [3:0] rd_piece;
  logic       turn, init_busy;
  int         tests = 0;
  int         failed = 0;
  logic [3:0] m_board [64];
  logic       m_turn;

  chess_board_state_if mi ();

  chess_board_state #(.FIRST_TURN(1'b0), .PROMOTE_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_new_game  (new_game),
    .i_rd_sq     (rd_sq),
    .o_rd_piece  (rd_piece),
    .o_turn      (turn),
    .o_init_busy (init_busy),
    .mv          (mi.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0] sx, sy, dx, dy;
    logic       col;
    logic [1:0] st;
    logic [3:0] cap;
    logic [3:0] dst_after;
  } vec_t;

  typedef struct {
    int         sq;
    logic [3:0] v;
  } rd_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_init();
    logic [2:0] back [8];
    back = '{3'd4, 3'd3, 3'd2, 3'd6, 3'd5, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 64; i++) begin
      case (i / 8)
        0:       m_board[i] = {1'b1, back[i % 8]};
        1:       m_board[i] = 4'h9;
        6:       m_board[i] = 4'h1;
        7:       m_board[i] = {1'b0, back[i % 8]};
        default: m_board[i] = 4'h0;
      endcase
    end
    m_turn = 1'b0;
  endfunction

  task automatic model_move(input int s, input int d, input logic col, output logic [1:0] st, output logic [3:0] cap);
    logic [3:0] p;
    p = m_board[s];
    cap = 4'h0;
    if (col !== m_turn) st = 2'd1;
    else if (p[2:0] == 3'd0 || p[3] != col) st = 2'd2;
    else if (s == d || (m_board[d] != 4'h0 && m_board[d][3] == col)) st = 2'd3;
    else begin
      st = 2'd0;
      cap = m_board[d];
      m_board[d] = (p[2:0] == 3'd1 && d / 8 == (col ? 7 : 0)) ? {col, 3'd5} : p;
      m_board[s] = 4'h0;
      m_turn = ~m_turn;
    end
  endtask

  task automatic read_sq(input int i, output logic [3:0] v);
    @(negedge clk);
    rd_sq = i[5:0];
    @(posedge clk);
    #1 v = rd_piece;
  endtask

  task automatic check_board(input string tag);
    logic [3:0] v;
    for (int i = 0; i < 64; i++) begin
      read_sq(i, v);
      check($sformatf("%s sq%0d", tag, i), v, m_board[i]);
    end
  endtask

  task automatic do_move(input logic [2:0] sx, sy, dx, dy, input logic col,
                         output logic [1:0] st, output logic [3:0] cap, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!mi.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready before move", mi.ready, 1'b1);
    mi.src_x = sx; mi.src_y = sy; mi.dst_x = dx; mi.dst_y = dy; mi.colour = col;
    mi.valid = 1'b1;
    @(posedge clk);
    #1 mi.valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (mi.done) break;
    end
    if (!mi.done) lat = 99;
    st = mi.status;
    cap = mi.captured;
  endtask

  task automatic wait_no_done(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (mi.done) seen++;
    end
    check({tag, " no mv_done"}, seen, 0);
  endtask

  initial begin
    vec_t       vt [12];
    rd_t        init_rd [5];
    logic [1:0] st, est;
    logic [3:0] cap, ecap, v;
    int         lat, s, d;
    logic       col;
    mi.valid = 1'b0; mi.src_x = '0; mi.src_y = '0; mi.dst_x = '0; mi.dst_y = '0; mi.colour = 1'b0;
    init_rd = '{'{0, 4'hC}, '{3, 4'hE}, '{59, 4'h6}, '{52, 4'h1}, '{36, 4'h0}};
    vt[0]  = '{3'd4, 3'd6, 3'd4, 3'd4, 1'b0, 2'd0, 4'h0, 4'h1};
    vt[1]  = '{3'd4, 3'd4, 3'd4, 3'd3, 1'b0, 2'd1, 4'h0, 4'h0};
    vt[2]  = '{3'd0, 3'd4, 3'd0, 3'd5, 1'b1, 2'd2, 4'h0, 4'h0};
    vt[3]  = '{3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 2'd3, 4'h0, 4'hB};
    vt[4]  = '{3'd4, 3'd1, 3'd4, 3'd1, 1'b1, 2'd3, 4'h0, 4'h9};
    vt[5]  = '{3'd4, 3'd1, 3'd4, 3'd3, 1'b1, 2'd0, 4'h0, 4'h9};
    vt[6]  = '{3'd4, 3'd4, 3'd4, 3'd3, 1'b0, 2'd0, 4'h9, 4'h1};
    vt[7]  = '{3'd4, 3'd3, 3'd4, 3'd4, 1'b1, 2'd2, 4'h0, 4'h0};
    vt[8]  = '{3'd0, 3'd1, 3'd0, 3'd2, 1'b1, 2'd0, 4'h0, 4'h9};
    vt[9]  = '{3'd3, 3'd6, 3'd3, 3'd1, 1'b0, 2'd0, 4'h9, 4'h1};
    vt[10] = '{3'd7, 3'd1, 3'd7, 3'd2, 1'b1, 2'd0, 4'h0, 4'h9};
    vt[11] = '{3'd3, 3'd1, 3'd2, 3'd0, 1'b0, 2'd0, 4'hA, 4'h5};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset init_busy", init_busy, 1'b1);
    check("reset turn", turn, 1'b0);
    check("reset ready", mi.ready, 1'b0);
    check("reset done", mi.done, 1'b0);
    check("reset status", mi.status, 2'd0);
    check("reset captured", mi.captured, 4'h0);
    check("reset rd_piece", rd_piece, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (63) @(posedge clk);
    #1;
    check("init busy at 63", init_busy, 1'b1);
    check("rd_piece 0 while busy", rd_piece, 4'h0);
    @(posedge clk);
    #1;
    check("init done at 64", init_busy, 1'b0);
    check("ready after init", mi.ready, 1'b1);
    model_init();
    foreach (init_rd[i]) begin
      read_sq(init_rd[i].sq, v);
      check($sformatf("init sq%0d", init_rd[i].sq), v, init_rd[i].v);
    end

    // directed move table
    for (int i = 0; i < 12; i++) begin
      s = vt[i].sy * 8 + vt[i].sx;
      d = vt[i].dy * 8 + vt[i].dx;
      model_move(s, d, vt[i].col, est, ecap);
      do_move(vt[i].sx, vt[i].sy, vt[i].dx, vt[i].dy, vt[i].col, st, cap, lat);
      check($sformatf("vec%0d status", i), st, vt[i].st);
      check($sformatf("vec%0d captured", i), cap, vt[i].cap);
      check($sformatf("vec%0d latency", i), lat, vt[i].st == 2'd0 ? 5 : 3);
      check($sformatf("vec%0d turn", i), turn, m_turn);
      read_sq(d, v);
      check($sformatf("vec%0d dst", i), v, vt[i].dst_after);
      read_sq(s, v);
      check($sformatf("vec%0d src", i), v, m_board[s]);
    end
    check_board("after table");

    // reset during WR_DST: move dropped, start position and FIRST_TURN restored
    @(negedge clk);
    mi.src_x = 3'd7; mi.src_y = 3'd2; mi.dst_x = 3'd7; mi.dst_y = 3'd3; mi.colour = 1'b1;
    mi.valid = 1'b1;
    @(posedge clk);
    #1 mi.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midmove reset busy", init_busy, 1'b1);
    check("midmove reset turn", turn, 1'b0);
    check("midmove reset ready", mi.ready, 1'b0);
    wait_no_done(3, "reset hold");
    @(negedge clk);
    rst_n = 1'b1;
    wait_no_done(64, "reinit");
    check("reinit busy", init_busy, 1'b0);
    model_init();
    check_board("after reset");

    // new_game together with mv_valid: request ignored, INIT reruns
    @(negedge clk);
    mi.src_x = 3'd0; mi.src_y = 3'd6; mi.dst_x = 3'd0; mi.dst_y = 3'd5; mi.colour = 1'b0;
    mi.valid = 1'b1;
    new_game = 1'b1;
    @(posedge clk);
    #1;
    mi.valid = 1'b0;
    new_game = 1'b0;
    check("new_game busy", init_busy, 1'b1);
    check("new_game ready", mi.ready, 1'b0);
    wait_no_done(64, "new_game");
    check("new_game init done", init_busy, 1'b0);
    read_sq(48, v);
    check("new_game sq48 kept", v, 4'h1);
    read_sq(40, v);
    check("new_game sq40 empty", v, 4'h0);

    // random moves against the model
    for (int k = 0; k < 40; k++) begin
      col = ($urandom_range(0, 3) != 0) ? m_turn : ~m_turn;
      s = $urandom_range(0, 63);
      if ($urandom_range(0, 2) != 0)
        for (int t = 0; t < 30 && !(m_board[s] != 4'h0 && m_board[s][3] == col); t++) s = $urandom_range(0, 63);
      d = $urandom_range(0, 63);
      model_move(s, d, col, est, ecap);
      do_move(s[2:0], s[5:3], d[2:0], d[5:3], col, st, cap, lat);
      check($sformatf("rnd%0d status", k), st, est);
      check($sformatf("rnd%0d captured", k), cap, ecap);
      check($sformatf("rnd%0d latency", k), lat, est == 2'd0 ? 5 : 3);
      check($sformatf("rnd%0d turn", k), turn, m_turn);
      read_sq(d, v);
      check($sformatf("rnd%0d dst", k), v, m_board[d]);
      read_sq(s, v);
      check($sformatf("rnd%0d src", k), v, m_board[s]);
    end
    check_board("after random");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
